id_ex_register: RTL and testbench
=================================

// Module: id_ex_register
// PURPOSE
//  ID/EX pipeline register directly downstream of the control unit: captures the decoded control bundle,
//  register-file operands, immediate and register specifiers each cycle and presents them to EX.
//  Owns load-use hazard detection (stalls PC/IF-ID, injects a bubble), honours branch flush from EX
//  and whole-pipe hold on cache miss. Keeps saturating bubble/hold counters for performance runs.
// PARAMETERS
//  DATA_W   32  width of PC+4, operands and sign-extended immediate
//  REG_W    5   register specifier width
//  CNT_W    16  width of performance counters (saturating)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  idValid      in   1       ID holds a real instruction
//  regDst,aluSrc,memToReg,regWrite,memRead,memWrite,branch  in 1 each  control-unit outputs
//  aluOp        in   3       control-unit ALU op class
//  idPcPlus4    in   DATA_W  PC+4 of ID instruction
//  idRs1Data    in   DATA_W  register-file read port 1
//  idRs2Data    in   DATA_W  register-file read port 2
//  idImm        in   DATA_W  sign-extended immediate
//  idRs,idRt,idRd in REG_W   source/dest specifiers from instruction
//  memStall     in   1       cache miss: freeze whole pipe
//  flush        in   1       branch taken in EX: kill ID instruction
//  hazardStall  out  1       combinational: hold PC and IF/ID this cycle
//  exValid      out  1       EX slot holds a real instruction
//  exRegDst..exBranch out 1 each, exAluOp out 3  registered control bundle
//  exPcPlus4,exRs1Data,exRs2Data,exImm  out DATA_W  registered data
//  exRs,exRt,exRd  out REG_W registered specifiers
//  bubbleCount  out  CNT_W   bubbles injected (hazard + flush)
//  holdCount    out  CNT_W   cycles frozen by memStall
// BEHAVIOUR
//  Reset (rst_n=0, async): every registered output, exValid and both counters = 0 immediately.
//  Bubble = exValid 0 and all ten control bits 0; data/specifier fields are don't-care but driven 0.
//  usesRt = regDst | memWrite | branch (R-type, store, beq/bne read rt).
//  hazardStall = exValid & exMemRead & (exRt!=0) & idValid & ((exRt==idRs) | (usesRt & exRt==idRt)).
//  Per rising edge, strict priority:
//   1. memStall=1      -> hold all fields unchanged; holdCount+=1 (saturate at all-ones).
//   2. flush=1         -> load bubble; bubbleCount+=1 if idValid (killed a real instruction).
//   3. hazardStall=1   -> load bubble; bubbleCount+=1.
//   4. otherwise       -> load ID fields; exValid<=idValid; if idValid=0 load control bits 0.
//  Latency: one cycle ID->EX. No combinational path from inputs to ex* outputs.
//  hazardStall is combinational on registered EX fields + ID inputs; during memStall it keeps its
//   value (EX frozen) and the source must tolerate that; it is never asserted on reset.
//  memStall+flush together: hold wins; flush source must keep flush high until memStall drops.
//  flush+hazard together: one bubble, counted once.
//  Register $0 never causes a hazard. Counters saturate, never wrap.
//  Reset mid-operation clears state at once; first post-reset edge behaves as from idle.
// STRUCTURE
//  Shared include PipelineDefs.v: DATA_W/REG_W defaults, CTRL_W=10, control-bundle bit positions,
//   BUBBLE_CTRL=10'b0 constant, opcode localparams used by the bench.
//  One sub-module: load_use_detect (pure combinational hazardStall computation, reused by forwarding work).
//  Remainder: one always block for the pipeline register, one for the two counters.
// TESTING
//  1. Reset held, inputs toggling -> all outputs 0, hazardStall 0; release -> first edge loads ID.
//  2. R-type (regDst=1,regWrite=1,aluOp=3'b010, rs=1,rt=2,rd=3) idle pipe -> exact copy at exOutputs
//     next edge, exValid=1, bubbleCount=0.
//  3. lw rt=5 in EX, add rs=5 in ID -> hazardStall=1 same cycle; next edge exValid=0, ctrl=0,
//     bubbleCount=1; following edge the add loads; lw rt=0 case -> no stall.
//  4. flush=1 with valid ID beq -> bubble, bubbleCount+=1; flush with idValid=0 -> bubble, no count.
//  5. memStall=1 for 4 cycles with flush=1 -> ex* unchanged, holdCount=4; drop memStall -> bubble.
//  6. Force holdCount to 16'hFFFE, stall 3 cycles -> 16'hFFFF and stays; async reset mid-stall -> 0.

Source files
------------

// File: rtl/id_ex_register_pkg.sv
// rtl/id_ex_register_pkg.sv - shared widths, control bundle type and helpers for the ID/EX stage
package id_ex_register_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;
    localparam int CTRL_W = 10;

    // Field order fixes the control-bundle bit positions: regDst is bit 9, aluOp is [2:0].
    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic       memToReg;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic [2:0] aluOp;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    // R-type, stores and beq/bne are the only classes that read rt as a source.
    function automatic logic usesRt(input ctrl_t c);
        return c.regDst | c.memWrite | c.branch;
    endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// rtl/id_ex_register_if.sv - ID-side bundle in, EX-side bundle and status out of the ID/EX register
interface id_ex_register_if #(
    parameter int DATA_W = id_ex_register_pkg::DATA_W,
    parameter int REG_W  = id_ex_register_pkg::REG_W,
    parameter int CNT_W  = id_ex_register_pkg::CNT_W
) ();

    logic              idValid;
    logic              regDst;
    logic              aluSrc;
    logic              memToReg;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              branch;
    logic [2:0]        aluOp;
    logic [DATA_W-1:0] idPcPlus4;
    logic [DATA_W-1:0] idRs1Data;
    logic [DATA_W-1:0] idRs2Data;
    logic [DATA_W-1:0] idImm;
    logic [REG_W-1:0]  idRs;
    logic [REG_W-1:0]  idRt;
    logic [REG_W-1:0]  idRd;
    logic              memStall;
    logic              flush;

    logic              hazardStall;
    logic              exValid;
    logic              exRegDst;
    logic              exAluSrc;
    logic              exMemToReg;
    logic              exRegWrite;
    logic              exMemRead;
    logic              exMemWrite;
    logic              exBranch;
    logic [2:0]        exAluOp;
    logic [DATA_W-1:0] exPcPlus4;
    logic [DATA_W-1:0] exRs1Data;
    logic [DATA_W-1:0] exRs2Data;
    logic [DATA_W-1:0] exImm;
    logic [REG_W-1:0]  exRs;
    logic [REG_W-1:0]  exRt;
    logic [REG_W-1:0]  exRd;
    logic [CNT_W-1:0]  bubbleCount;
    logic [CNT_W-1:0]  holdCount;

    modport master (
        output idValid, regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp,
               idPcPlus4, idRs1Data, idRs2Data, idImm, idRs, idRt, idRd, memStall, flush,
        input  hazardStall, exValid, exRegDst, exAluSrc, exMemToReg, exRegWrite, exMemRead,
               exMemWrite, exBranch, exAluOp, exPcPlus4, exRs1Data, exRs2Data, exImm,
               exRs, exRt, exRd, bubbleCount, holdCount
    );

    modport slave (
        input  idValid, regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp,
               idPcPlus4, idRs1Data, idRs2Data, idImm, idRs, idRt, idRd, memStall, flush,
        output hazardStall, exValid, exRegDst, exAluSrc, exMemToReg, exRegWrite, exMemRead,
               exMemWrite, exBranch, exAluOp, exPcPlus4, exRs1Data, exRs2Data, exImm,
               exRs, exRt, exRd, bubbleCount, holdCount
    );

endinterface

// File: rtl/id_ex_register_load_use_detect.sv
// rtl/id_ex_register_load_use_detect.sv - combinational load-use hazard check between EX load and ID sources
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             exValid,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRt,
    input  logic             idValid,
    input  logic             idUsesRt,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    output logic             hazardStall
);

    logic rsMatch;
    logic rtMatch;

    assign rsMatch = (exRt == idRs);
    assign rtMatch = idUsesRt & (exRt == idRt);

    // $0 is hardwired zero, so a load targeting it never produces a value to wait for.
    assign hazardStall = exValid & exMemRead & (exRt != '0) & idValid & (rsMatch | rtMatch);

endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with load-use stall, flush, hold and perf counters
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int DATA_W = id_ex_register_pkg::DATA_W,
    parameter int REG_W  = id_ex_register_pkg::REG_W,
    parameter int CNT_W  = id_ex_register_pkg::CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_register_if.slave bus
);

    ctrl_t             idCtrl;
    ctrl_t             exCtrl;
    logic              exValid;
    logic [DATA_W-1:0] exPcPlus4;
    logic [DATA_W-1:0] exRs1Data;
    logic [DATA_W-1:0] exRs2Data;
    logic [DATA_W-1:0] exImm;
    logic [REG_W-1:0]  exRs;
    logic [REG_W-1:0]  exRt;
    logic [REG_W-1:0]  exRd;
    logic [CNT_W-1:0]  bubbleCount;
    logic [CNT_W-1:0]  holdCount;
    logic              hazardStall;

    assign idCtrl = '{regDst:   bus.regDst,
                      aluSrc:   bus.aluSrc,
                      memToReg: bus.memToReg,
                      regWrite: bus.regWrite,
                      memRead:  bus.memRead,
                      memWrite: bus.memWrite,
                      branch:   bus.branch,
                      aluOp:    bus.aluOp};

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .exValid     (exValid),
        .exMemRead   (exCtrl.memRead),
        .exRt        (exRt),
        .idValid     (bus.idValid),
        .idUsesRt    (usesRt(idCtrl)),
        .idRs        (bus.idRs),
        .idRt        (bus.idRt),
        .hazardStall (hazardStall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValid   <= 1'b0;
            exCtrl    <= BUBBLE_CTRL;
            exPcPlus4 <= '0;
            exRs1Data <= '0;
            exRs2Data <= '0;
            exImm     <= '0;
            exRs      <= '0;
            exRt      <= '0;
            exRd      <= '0;
        end else if (bus.memStall) begin
            // Whole pipe frozen: every EX field keeps its value.
        end else if (bus.flush || hazardStall) begin
            exValid   <= 1'b0;
            exCtrl    <= BUBBLE_CTRL;
            exPcPlus4 <= '0;
            exRs1Data <= '0;
            exRs2Data <= '0;
            exImm     <= '0;
            exRs      <= '0;
            exRt      <= '0;
            exRd      <= '0;
        end else begin
            exValid   <= bus.idValid;
            exCtrl    <= bus.idValid ? idCtrl : BUBBLE_CTRL;
            exPcPlus4 <= bus.idPcPlus4;
            exRs1Data <= bus.idRs1Data;
            exRs2Data <= bus.idRs2Data;
            exImm     <= bus.idImm;
            exRs      <= bus.idRs;
            exRt      <= bus.idRt;
            exRd      <= bus.idRd;
        end
    end

    // A flush only counts when it killed a real instruction; a coincident hazard is the same bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubbleCount <= '0;
            holdCount   <= '0;
        end else if (bus.memStall) begin
            if (!(&holdCount)) holdCount <= holdCount + 1'b1;
        end else if ((bus.flush && bus.idValid) || (!bus.flush && hazardStall)) begin
            if (!(&bubbleCount)) bubbleCount <= bubbleCount + 1'b1;
        end
    end

    assign bus.hazardStall = hazardStall;
    assign bus.exValid     = exValid;
    assign bus.exRegDst    = exCtrl.regDst;
    assign bus.exAluSrc    = exCtrl.aluSrc;
    assign bus.exMemToReg  = exCtrl.memToReg;
    assign bus.exRegWrite  = exCtrl.regWrite;
    assign bus.exMemRead   = exCtrl.memRead;
    assign bus.exMemWrite  = exCtrl.memWrite;
    assign bus.exBranch    = exCtrl.branch;
    assign bus.exAluOp     = exCtrl.aluOp;
    assign bus.exPcPlus4   = exPcPlus4;
    assign bus.exRs1Data   = exRs1Data;
    assign bus.exRs2Data   = exRs2Data;
    assign bus.exImm       = exImm;
    assign bus.exRs        = exRs;
    assign bus.exRt        = exRt;
    assign bus.exRd        = exRd;
    assign bus.bubbleCount = bubbleCount;
    assign bus.holdCount   = holdCount;

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - directed self-checking bench for id_ex_register
module tb_id_ex_register;
    import id_ex_register_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    id_ex_register_if bus ();

    id_ex_register dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] exCtrlBits();
        return {bus.exRegDst, bus.exAluSrc, bus.exMemToReg, bus.exRegWrite, bus.exMemRead,
                bus.exMemWrite, bus.exBranch, bus.exAluOp};
    endfunction

    task automatic clearId();
        bus.idValid = 0; bus.regDst = 0; bus.aluSrc = 0; bus.memToReg = 0; bus.regWrite = 0;
        bus.memRead = 0; bus.memWrite = 0; bus.branch = 0; bus.aluOp = 3'b000;
        bus.idPcPlus4 = '0; bus.idRs1Data = '0; bus.idRs2Data = '0; bus.idImm = '0;
        bus.idRs = '0; bus.idRt = '0; bus.idRd = '0;
    endtask

    task automatic setRtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clearId();
        bus.idValid = 1; bus.regDst = 1; bus.regWrite = 1; bus.aluOp = ALU_FUNCT;
        bus.idRs = rs; bus.idRt = rt; bus.idRd = rd;
        bus.idPcPlus4 = 32'h0000_0104; bus.idRs1Data = 32'h1111_0001;
        bus.idRs2Data = 32'h2222_0002; bus.idImm = 32'hFFFF_FFF3;
    endtask

    task automatic setLw(input logic [4:0] rs, input logic [4:0] rt);
        clearId();
        bus.idValid = 1; bus.aluSrc = 1; bus.memToReg = 1; bus.regWrite = 1; bus.memRead = 1;
        bus.aluOp = ALU_ADD; bus.idRs = rs; bus.idRt = rt; bus.idImm = 32'h0000_0010;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.memStall = 0; bus.flush = 0;
        for (int i = 0; i < 4; i++) begin
            setRtype(5'(i + 1), 5'(i + 2), 5'(i + 3));
            bus.flush = i[0];
            step();
        end
        bus.flush = 0;
        tests++; if (bus.exValid !== 1'b0) begin fails++; $display("FAIL reset_exValid: got %b expected 0", bus.exValid); end
        tests++; if (exCtrlBits() !== 10'b0) begin fails++; $display("FAIL reset_ctrl: got %b expected 0", exCtrlBits()); end
        tests++; if (bus.exRs1Data !== 32'h0 || bus.exRd !== 5'h0) begin fails++; $display("FAIL reset_data: got %h/%h expected 0/0", bus.exRs1Data, bus.exRd); end
        tests++; if (bus.hazardStall !== 1'b0) begin fails++; $display("FAIL reset_hazard: got %b expected 0", bus.hazardStall); end
        tests++; if (bus.bubbleCount !== 16'h0 || bus.holdCount !== 16'h0) begin fails++; $display("FAIL reset_counts: got %h/%h expected 0/0", bus.bubbleCount, bus.holdCount); end
        setRtype(5'd9, 5'd10, 5'd11);
        rst_n = 1;
        step();
        tests++; if (bus.exValid !== 1'b1 || bus.exRd !== 5'd11) begin fails++; $display("FAIL reset_release_load: got %b/%h expected 1/0b", bus.exValid, bus.exRd); end
    endtask

    task automatic test_rtype();
        setRtype(5'd1, 5'd2, 5'd3);
        step();
        tests++; if (bus.exValid !== 1'b1) begin fails++; $display("FAIL rtype_valid: got %b expected 1", bus.exValid); end
        tests++; if (exCtrlBits() !== 10'b1001_000_010) begin fails++; $display("FAIL rtype_ctrl: got %b expected 1001000010", exCtrlBits()); end
        tests++; if ({bus.exRs, bus.exRt, bus.exRd} !== {5'd1, 5'd2, 5'd3}) begin fails++; $display("FAIL rtype_regs: got %0d/%0d/%0d expected 1/2/3", bus.exRs, bus.exRt, bus.exRd); end
        tests++; if (bus.exPcPlus4 !== 32'h104 || bus.exRs1Data !== 32'h1111_0001 || bus.exRs2Data !== 32'h2222_0002 || bus.exImm !== 32'hFFFF_FFF3) begin
            fails++; $display("FAIL rtype_data: got %h %h %h %h expected 00000104 11110001 22220002 fffffff3", bus.exPcPlus4, bus.exRs1Data, bus.exRs2Data, bus.exImm); end
        tests++; if (bus.bubbleCount !== 16'd0) begin fails++; $display("FAIL rtype_bubbles: got %0d expected 0", bus.bubbleCount); end
    endtask

    task automatic test_load_use();
        setLw(5'd1, 5'd5);
        step();
        setRtype(5'd5, 5'd6, 5'd7);
        #1;
        tests++; if (bus.hazardStall !== 1'b1) begin fails++; $display("FAIL lu_stall_rs: got %b expected 1", bus.hazardStall); end
        step();
        tests++; if (bus.exValid !== 1'b0 || exCtrlBits() !== 10'b0) begin fails++; $display("FAIL lu_bubble: got %b/%b expected 0/0", bus.exValid, exCtrlBits()); end
        tests++; if (bus.bubbleCount !== 16'd1) begin fails++; $display("FAIL lu_count: got %0d expected 1", bus.bubbleCount); end
        tests++; if (bus.hazardStall !== 1'b0) begin fails++; $display("FAIL lu_stall_clear: got %b expected 0", bus.hazardStall); end
        step();
        tests++; if (bus.exValid !== 1'b1 || bus.exRs !== 5'd5 || bus.exRegDst !== 1'b1) begin fails++; $display("FAIL lu_add_loaded: got %b/%0d/%b expected 1/5/1", bus.exValid, bus.exRs, bus.exRegDst); end
        setLw(5'd1, 5'd0);
        step();
        setRtype(5'd0, 5'd0, 5'd8);
        #1;
        tests++; if (bus.hazardStall !== 1'b0) begin fails++; $display("FAIL lu_r0: got %b expected 0", bus.hazardStall); end
        step();
        tests++; if (bus.exValid !== 1'b1 || bus.bubbleCount !== 16'd1) begin fails++; $display("FAIL lu_r0_load: got %b/%0d expected 1/1", bus.exValid, bus.bubbleCount); end
        // store reads rt, so a load into its rt stalls
        setLw(5'd1, 5'd7);
        step();
        clearId();
        bus.idValid = 1; bus.memWrite = 1; bus.aluSrc = 1; bus.idRs = 5'd2; bus.idRt = 5'd7;
        #1;
        tests++; if (bus.hazardStall !== 1'b1) begin fails++; $display("FAIL lu_store_rt: got %b expected 1", bus.hazardStall); end
        step();
        tests++; if (bus.bubbleCount !== 16'd2) begin fails++; $display("FAIL lu_store_count: got %0d expected 2", bus.bubbleCount); end
        // addi writes rt rather than reading it, so no stall
        setLw(5'd1, 5'd7);
        step();
        clearId();
        bus.idValid = 1; bus.aluSrc = 1; bus.regWrite = 1; bus.idRs = 5'd2; bus.idRt = 5'd7;
        #1;
        tests++; if (bus.hazardStall !== 1'b0) begin fails++; $display("FAIL lu_addi_rt: got %b expected 0", bus.hazardStall); end
        step();
        tests++; if (bus.exValid !== 1'b1 || bus.exRt !== 5'd7 || bus.bubbleCount !== 16'd2) begin fails++; $display("FAIL lu_addi_load: got %b/%0d/%0d expected 1/7/2", bus.exValid, bus.exRt, bus.bubbleCount); end
    endtask

    task automatic test_flush();
        clearId();
        bus.idValid = 1; bus.branch = 1; bus.aluOp = ALU_SUB; bus.idRs = 5'd3; bus.idRt = 5'd4;
        bus.flush = 1;
        step();
        tests++; if (bus.exValid !== 1'b0 || exCtrlBits() !== 10'b0 || bus.bubbleCount !== 16'd3) begin fails++; $display("FAIL flush_valid: got %b/%b/%0d expected 0/0/3", bus.exValid, exCtrlBits(), bus.bubbleCount); end
        bus.idValid = 0;
        step();
        tests++; if (bus.exValid !== 1'b0 || bus.bubbleCount !== 16'd3) begin fails++; $display("FAIL flush_invalid: got %b/%0d expected 0/3", bus.exValid, bus.bubbleCount); end
        bus.flush = 0;
        setLw(5'd1, 5'd5);
        step();
        setRtype(5'd5, 5'd6, 5'd7);
        bus.flush = 1;
        step();
        tests++; if (bus.exValid !== 1'b0 || bus.bubbleCount !== 16'd4) begin fails++; $display("FAIL flush_hazard_once: got %b/%0d expected 0/4", bus.exValid, bus.bubbleCount); end
        bus.flush = 0;
    endtask

    task automatic test_hold();
        setRtype(5'd12, 5'd13, 5'd14);
        step();
        bus.memStall = 1; bus.flush = 1;
        setRtype(5'd20, 5'd21, 5'd22);
        for (int i = 0; i < 4; i++) step();
        tests++; if (bus.exValid !== 1'b1 || bus.exRd !== 5'd14 || bus.exRs !== 5'd12) begin fails++; $display("FAIL hold_frozen: got %b/%0d/%0d expected 1/14/12", bus.exValid, bus.exRd, bus.exRs); end
        tests++; if (bus.holdCount !== 16'd4 || bus.bubbleCount !== 16'd4) begin fails++; $display("FAIL hold_count: got %0d/%0d expected 4/4", bus.holdCount, bus.bubbleCount); end
        bus.memStall = 0;
        step();
        tests++; if (bus.exValid !== 1'b0 || bus.bubbleCount !== 16'd5) begin fails++; $display("FAIL hold_release_flush: got %b/%0d expected 0/5", bus.exValid, bus.bubbleCount); end
        bus.flush = 0;
    endtask

    task automatic test_saturate();
        bus.memStall = 1;
        for (int i = 0; i < 65530; i++) begin
            @(posedge clk);
        end
        #1;
        tests++; if (bus.holdCount !== 16'hFFFE) begin fails++; $display("FAIL sat_pre: got %h expected fffe", bus.holdCount); end
        for (int i = 0; i < 3; i++) step();
        tests++; if (bus.holdCount !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h expected ffff", bus.holdCount); end
        #2;
        rst_n = 0;
        #1;
        tests++; if (bus.holdCount !== 16'h0 || bus.bubbleCount !== 16'h0 || bus.exValid !== 1'b0) begin fails++; $display("FAIL async_reset: got %h/%h/%b expected 0/0/0", bus.holdCount, bus.bubbleCount, bus.exValid); end
        bus.memStall = 0;
        setRtype(5'd1, 5'd2, 5'd3);
        step();
        rst_n = 1;
        step();
        tests++; if (bus.exValid !== 1'b1 || bus.exRd !== 5'd3 || bus.holdCount !== 16'h0) begin fails++; $display("FAIL post_reset_load: got %b/%0d/%h expected 1/3/0", bus.exValid, bus.exRd, bus.holdCount); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clearId();
        test_reset();
        test_rtype();
        test_load_use();
        test_flush();
        test_hold();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
